// File: rtl/hc4_pkg.sv
// Shared definitions for the program-memory loader and the CPU fetch path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package hc4_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int MAX_LEN = 2 ** ADDR_W;

    localparam logic [DATA_W-1:0] PROG_HEADER = 8'hA5;

    typedef enum logic [3:0] {
        IDLE,
        LEN_H,
        LEN_L,
        ADR_H,
        ADR_L,
        DATA,
        CSUM,
        DONE,
        ERR
    } ld_state_t;

endpackage

// File: rtl/prog_loader_csum.sv
// 8-bit running-sum accumulator with clear and add-enable; flags a zero next sum.
// Latency: sum updates on the edge after add_en; nxt_zero is combinational.
// Backpressure: none, follows the caller's enables.
// Ports: clk/rst, clr (zero the sum), add_en + add_dat (accumulate),
//        nxt_zero (current sum plus add_dat wraps to 0x00).
module prog_loader_csum
    import hc4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_dat,
    output logic              nxt_zero
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] nxt_sum;

    assign nxt_sum  = sum + add_dat;
    // The checksum byte itself is part of the sum, so the verdict looks at
    // the value the sum is about to take rather than the stored one.
    assign nxt_zero = (nxt_sum == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= nxt_sum;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Fills the 4096x8 program RAM from a framed byte stream and holds the CPU meanwhile.
// Latency: a data byte accepted at edge N is written during cycle N+1; done/err one cycle after CSUM.
// Backpressure: in_ready drops only for the single DONE/ERR cycle; otherwise every byte is taken.
// Ports: clk/rst; in_valid/in_data/in_ready byte stream; mem_we/mem_addr/mem_wdata
//        RAM write port; cpu_hold CPU stall; done/err one-cycle result pulses.
module prog_loader
    import hc4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // Count must hold MAX_LEN itself, hence one bit wider than the address.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [2*DATA_W-1:0] MAX_LEN_V = (2*DATA_W)'(MAX_LEN);

    ld_state_t          state;
    ld_state_t          state_nxt;
    logic               acc;
    logic               sum_clr;
    logic               sum_add;
    logic               sum_zero;
    logic [DATA_W-1:0]  len_h;
    logic [CNT_W-1:0]   len;
    logic [3:0]         adr_h;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   cnt;
    logic [2*DATA_W-1:0] len_full;
    logic               len_ok;

    assign in_ready = (state != DONE) && (state != ERR);
    assign done     = (state == DONE);
    assign err      = (state == ERR);
    assign acc      = in_valid && in_ready;

    assign len_full = {len_h, in_data};
    assign len_ok   = (len_full != '0) && (len_full <= MAX_LEN_V);

    // Every accepted byte after the header, through CSUM, feeds the sum.
    assign sum_add  = acc && (state != IDLE);

    prog_loader_csum u_csum (
        .clk      (clk),
        .rst      (rst),
        .clr      (sum_clr),
        .add_en   (sum_add),
        .add_dat  (in_data),
        .nxt_zero (sum_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sum_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (acc && (in_data == PROG_HEADER)) begin
                    state_nxt = LEN_H;
                    sum_clr   = 1'b1;
                end
            end
            LEN_H: if (acc) state_nxt = LEN_L;
            LEN_L: if (acc) state_nxt = len_ok ? ADR_H : ERR;
            ADR_H: if (acc) state_nxt = ADR_L;
            ADR_L: if (acc) state_nxt = DATA;
            DATA:  if (acc && (cnt == CNT_W'(1))) state_nxt = CSUM;
            CSUM:  if (acc) state_nxt = sum_zero ? DONE : ERR;
            DONE:  state_nxt = IDLE;
            ERR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_h     <= '0;
            len       <= '0;
            adr_h     <= '0;
            addr      <= '0;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            cpu_hold <= (state_nxt != IDLE);
            if (acc) begin
                case (state)
                    LEN_H: len_h <= in_data;
                    // Only reached with a legal length when it matters (ERR otherwise).
                    LEN_L: len   <= len_full[CNT_W-1:0];
                    ADR_H: adr_h <= in_data[3:0];
                    ADR_L: begin
                        addr <= {adr_h, in_data};
                        cnt  <= len;
                    end
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= in_data;
                        addr      <= addr + 1'b1;   // wraps 0xFFF -> 0x000
                        cnt       <= cnt - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
